dsp_result_collector: RTL and testbench



---
 rtl/dsp_result_collector.sv | 169 ++++++++++++++++
 tb/tb_dsp_result_collector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_result_collector.sv
// dsp_result_collector
//
// Result-side companion to a DSP48A1-style pipeline. It tracks which issued
// operations are travelling through the slice's registered stages and, when an
// operation reaches the end of the pipeline, captures the P output into a
// small show-ahead FIFO. The FIFO drains on a valid/ready stream. The slice's
// shared clock enable (CE) is driven from here, so a stalled consumer freezes
// the whole DSP pipeline and no result is ever dropped.
//
// Optional feature: define DSP_COLLECT_TAG_EN to carry a per-operation tag
// alongside each result (adds TAG_W, TAG_IN and TAG_OUT).
//
// Parameters
//   WIDTH    result width (P bus)
//   LATENCY  registered DSP stages between issue and valid P (0..8)
//   DEPTH    result FIFO entries (power of two, 2..16)
//   TAG_W    tag width (DSP_COLLECT_TAG_EN only)
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous active-high reset
//   IN_VALID   operation presented to the DSP this cycle (taken when CE=1)
//   P_IN       DSP P output
//   CE         clock enable to every DSP register; also issue-ready
//   OUT_VALID  FIFO head valid
//   OUT_DATA   FIFO head result
//   OUT_READY  consumer accepts the head this cycle
//   TAG_IN     operation tag (DSP_COLLECT_TAG_EN only)
//   TAG_OUT    tag of the FIFO head (DSP_COLLECT_TAG_EN only)
//   INFLIGHT   number of accepted operations not yet captured

module dsp_result_collector #(
    parameter int unsigned WIDTH   = 48,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 4
`ifdef DSP_COLLECT_TAG_EN
    ,
    parameter int unsigned TAG_W   = 4
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] P_IN,
    output logic             CE,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] OUT_DATA,
    input  logic             OUT_READY,
`ifdef DSP_COLLECT_TAG_EN
    input  logic [TAG_W-1:0] TAG_IN,
    output logic [TAG_W-1:0] TAG_OUT,
`endif
    output logic [3:0]       INFLIGHT
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] mem [DEPTH];

    logic cap_valid;
    logic push;
    logic pop;

`ifdef DSP_COLLECT_TAG_EN
    logic [TAG_W-1:0] cap_tag;
    logic [TAG_W-1:0] tag_mem [DEPTH];
`endif

    // A full FIFO only stalls the slice if the consumer is not draining this
    // cycle; a simultaneous pop frees the slot the capture needs.
    assign CE   = (count < CNT_W'(DEPTH)) || OUT_READY;
    assign push = CE && cap_valid;
    assign pop  = OUT_VALID && OUT_READY;

    generate
        if (LATENCY > 0) begin : g_pipe
            // vp mirrors the DSP register chain: bit k is set when the
            // operation sitting in stage k is a real one.
            logic [LATENCY-1:0] vp;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    vp <= '0;
                end else if (CE) begin
                    vp[0] <= IN_VALID;
                    for (int k = 1; k < LATENCY; k++) begin
                        vp[k] <= vp[k-1];
                    end
                end
            end

            assign cap_valid = vp[LATENCY-1];

            always_comb begin
                INFLIGHT = '0;
                for (int k = 0; k < LATENCY; k++) begin
                    INFLIGHT = INFLIGHT + {3'b000, vp[k]};
                end
            end

`ifdef DSP_COLLECT_TAG_EN
            logic [TAG_W-1:0] tp [LATENCY];

            always_ff @(posedge CLK) begin
                if (RST) begin
                    for (int k = 0; k < LATENCY; k++) begin
                        tp[k] <= '0;
                    end
                end else if (CE) begin
                    tp[0] <= TAG_IN;
                    for (int k = 1; k < LATENCY; k++) begin
                        tp[k] <= tp[k-1];
                    end
                end
            end

            assign cap_tag = tp[LATENCY-1];
`endif
        end else begin : g_comb
            // Combinational DSP path: P_IN belongs to the operation issued now.
            assign cap_valid = IN_VALID;
            assign INFLIGHT  = '0;
`ifdef DSP_COLLECT_TAG_EN
            assign cap_tag   = TAG_IN;
`endif
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
`ifdef DSP_COLLECT_TAG_EN
                tag_mem[i] <= '0;
`endif
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= P_IN;
`ifdef DSP_COLLECT_TAG_EN
                tag_mem[wr_ptr] <= cap_tag;
`endif
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign OUT_VALID = (count != '0);
    assign OUT_DATA  = mem[rd_ptr];
`ifdef DSP_COLLECT_TAG_EN
    assign TAG_OUT   = tag_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_dsp_result_collector.sv
// Testbench for dsp_result_collector. Two instances share clock and reset:
// one with LATENCY=4/DEPTH=4 fed by a small CE-gated model of the DSP pipe,
// one with LATENCY=0 fed combinationally. Tag checks are compiled in only
// when DSP_COLLECT_TAG_EN is defined.

module tb_dsp_result_collector;

    localparam int W = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // LATENCY=4 instance
    logic         iv, rdy, ce, ov;
    logic [W-1:0] p, p_in, od;
    logic [3:0]   infl;
    logic [W-1:0] dsp [4];

    // LATENCY=0 instance
    logic         iv0, rdy0, ce0, ov0;
    logic [W-1:0] p0, od0;
    logic [3:0]   infl0;

`ifdef DSP_COLLECT_TAG_EN
    logic [3:0] tag_in, tag_out, tag_in0, tag_out0;
`endif

    // DSP slice model: four CE-gated registers, reset by the same RST
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) dsp[i] <= '0;
        end else if (ce) begin
            dsp[0] <= iv ? p : '0;
            dsp[1] <= dsp[0];
            dsp[2] <= dsp[1];
            dsp[3] <= dsp[2];
        end
    end
    assign p_in = dsp[3];

    dsp_result_collector #(
        .WIDTH(W), .LATENCY(4), .DEPTH(4)
`ifdef DSP_COLLECT_TAG_EN
        , .TAG_W(4)
`endif
    ) u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(iv), .P_IN(p_in), .CE(ce),
        .OUT_VALID(ov), .OUT_DATA(od), .OUT_READY(rdy),
`ifdef DSP_COLLECT_TAG_EN
        .TAG_IN(tag_in), .TAG_OUT(tag_out),
`endif
        .INFLIGHT(infl)
    );

    dsp_result_collector #(
        .WIDTH(W), .LATENCY(0), .DEPTH(4)
`ifdef DSP_COLLECT_TAG_EN
        , .TAG_W(4)
`endif
    ) u_dut0 (
        .CLK(clk), .RST(rst), .IN_VALID(iv0), .P_IN(p0), .CE(ce0),
        .OUT_VALID(ov0), .OUT_DATA(od0), .OUT_READY(rdy0),
`ifdef DSP_COLLECT_TAG_EN
        .TAG_IN(tag_in0), .TAG_OUT(tag_out0),
`endif
        .INFLIGHT(infl0)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         iv;
        logic [W-1:0] p;
        logic         rdy;
        logic         ce;
        logic         ov;
        logic [W-1:0] od;
        logic [3:0]   infl;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int issued;
        int cycles;
        int k;
        int exp_v;
        logic accept;
        logic stale;

        // iv  p   rdy ce ov od  infl
        tbl[0] = '{1'b1, 48'd10, 1'b1, 1'b1, 1'b0, 48'd0,  4'd0};
        tbl[1] = '{1'b1, 48'd20, 1'b1, 1'b1, 1'b0, 48'd0,  4'd1};
        tbl[2] = '{1'b1, 48'd30, 1'b1, 1'b1, 1'b0, 48'd0,  4'd2};
        tbl[3] = '{1'b0, 48'd0,  1'b1, 1'b1, 1'b0, 48'd0,  4'd3};
        tbl[4] = '{1'b0, 48'd0,  1'b1, 1'b1, 1'b0, 48'd0,  4'd3};
        tbl[5] = '{1'b0, 48'd0,  1'b1, 1'b1, 1'b1, 48'd10, 4'd2};
        tbl[6] = '{1'b0, 48'd0,  1'b1, 1'b1, 1'b1, 48'd20, 4'd1};
        tbl[7] = '{1'b0, 48'd0,  1'b1, 1'b1, 1'b1, 48'd30, 4'd0};
        tbl[8] = '{1'b0, 48'd0,  1'b1, 1'b1, 1'b0, 48'd0,  4'd0};

        rst = 1'b1; iv = 1'b0; p = '0; rdy = 1'b0;
        iv0 = 1'b0; p0 = '0; rdy0 = 1'b1;
`ifdef DSP_COLLECT_TAG_EN
        tag_in = '0; tag_in0 = '0;
`endif
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Basic pipeline: 10,20,30 back to back, consumer always ready
        for (int i = 0; i < 9; i++) begin
            iv = tbl[i].iv; p = tbl[i].p; rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl[%0d] ce", i), ce, tbl[i].ce);
            chk($sformatf("tbl[%0d] out_valid", i), ov, tbl[i].ov);
            chk($sformatf("tbl[%0d] out_data", i), od, tbl[i].od);
            chk($sformatf("tbl[%0d] inflight", i), infl, tbl[i].infl);
            next_cycle();
        end
        iv = 1'b0;

        // Back-pressure: 8 ops with consumer stalled
        rdy = 1'b0;
        issued = 0;
        cycles = 0;
        while (issued < 8 && cycles < 40) begin
            iv = 1'b1;
            p = W'(100 + issued);
            @(negedge clk);
            accept = ce;
            next_cycle();
            if (accept) issued++;
            cycles++;
        end
        iv = 1'b0;
        chk("stall issued all", issued, 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall ce low", ce, 0);
            chk("stall inflight frozen", infl, 4);
            chk("stall head", od, 100);
            next_cycle();
        end

        // Full FIFO: one push+pop cycle keeps it full
        rdy = 1'b1;
        @(negedge clk);
        chk("full pushpop ce", ce, 1);
        chk("full pushpop head", od, 100);
        next_cycle();
        rdy = 1'b0;
        @(negedge clk);
        chk("still full ce", ce, 0);
        chk("still full valid", ov, 1);
        chk("still full head", od, 101);
        chk("still full inflight", infl, 3);
        next_cycle();

        // Drain the rest in order
        rdy = 1'b1;
        exp_v = 101;
        cycles = 0;
        while (exp_v < 108 && cycles < 40) begin
            @(negedge clk);
            if (ov) begin
                chk("drain data", od, exp_v);
                exp_v++;
            end
            next_cycle();
            cycles++;
        end
        chk("drain count", exp_v, 108);
        @(negedge clk);
        chk("drained empty", ov, 0);
        next_cycle();

        // LATENCY=0 instance
        iv0 = 1'b1; p0 = 48'h7;
        @(negedge clk);
        chk("lat0 ce", ce0, 1);
        chk("lat0 valid before", ov0, 0);
        chk("lat0 inflight", infl0, 0);
        next_cycle();
        iv0 = 1'b0; p0 = '0;
        @(negedge clk);
        chk("lat0 valid", ov0, 1);
        chk("lat0 data", od0, 48'h7);
        chk("lat0 inflight after", infl0, 0);
        next_cycle();
        @(negedge clk);
        chk("lat0 popped", ov0, 0);
        next_cycle();

        // Reset with 3 in flight and 2 buffered
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            iv = 1'b1; p = W'(50 + i);
            next_cycle();
        end
        iv = 1'b0; p = '0;
        next_cycle();
        @(negedge clk);
        chk("pre-reset inflight", infl, 3);
        chk("pre-reset valid", ov, 1);
        chk("pre-reset head", od, 50);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset valid", ov, 0);
        chk("post-reset inflight", infl, 0);
        chk("post-reset ce", ce, 1);
        chk("post-reset data", od, 0);
        next_cycle();
        rdy = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ov) stale = 1'b1;
            next_cycle();
        end
        chk("no stale result", stale, 0);

        // Fresh op after reset sees minimum latency LATENCY+1
        iv = 1'b1; p = 48'd77;
        next_cycle();
        iv = 1'b0; p = '0;
        k = 1;
        @(negedge clk);
        while (!ov && k < 20) begin
            next_cycle();
            k++;
            @(negedge clk);
        end
        chk("post-reset latency", k, 5);
        chk("post-reset data", od, 77);
        next_cycle();

`ifdef DSP_COLLECT_TAG_EN
        // Tags 1,2,3 with a two-cycle gap after the first
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: begin iv = 1'b1; p = 48'd11; tag_in = 4'd1; end
                3: begin iv = 1'b1; p = 48'd22; tag_in = 4'd2; end
                4: begin iv = 1'b1; p = 48'd33; tag_in = 4'd3; end
                default: begin iv = 1'b0; p = '0; tag_in = 4'd0; end
            endcase
            next_cycle();
        end
        iv = 1'b0; p = '0; tag_in = '0;
        exp_v = 0;
        cycles = 0;
        while (exp_v < 3 && cycles < 30) begin
            @(negedge clk);
            if (ov) begin
                chk("tag data", od, (exp_v == 0) ? 11 : (exp_v == 1) ? 22 : 33);
                chk("tag out", tag_out, exp_v + 1);
                exp_v++;
            end
            next_cycle();
            cycles++;
        end
        chk("tag count", exp_v, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
